// File: rtl/stream_sample_scheduler_if.sv
// Bundles the stream-sample control inputs and the status/sample outputs
// exchanged between the SPI register bank and the sample scheduler.
interface stream_sample_scheduler_if #(
  parameter int DEPTH_LOG2 = 3,
  parameter int DIV_W      = 16
);
  logic                  enable;
  logic                  flush;
  logic                  wr_valid;
  logic [7:0]            wr_data;
  logic [DIV_W-1:0]      rate_div;
  logic                  clear_flags;
  logic [7:0]            sample_out;
  logic                  sample_tick;
  logic [DEPTH_LOG2:0]   fifo_level;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  overflow;
  logic                  underrun;

  modport master (
    output enable, flush, wr_valid, wr_data, rate_div, clear_flags,
    input  sample_out, sample_tick, fifo_level, fifo_full, fifo_empty, overflow, underrun
  );

  modport slave (
    input  enable, flush, wr_valid, wr_data, rate_div, clear_flags,
    output sample_out, sample_tick, fifo_level, fifo_full, fifo_empty, overflow, underrun
  );
endinterface

// File: rtl/stream_sample_scheduler.sv
// Stream sample scheduler: buffers SPI-written sample bytes in a small FIFO
// and releases one per rate-divider period towards the mixer/DAC path.
// Reports FIFO level and sticky overflow/underrun flags.
module stream_sample_scheduler #(
  parameter int         DEPTH_LOG2    = 3,
  parameter int         DIV_W         = 16,
  parameter logic [7:0] MIDSCALE      = 8'h80,
  parameter bit         UNDERRUN_HOLD = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stream_sample_scheduler_if.slave bus
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DIV_W-1:0]      div_cnt;
  logic [7:0]            fifo_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  full_q;
  logic                  empty_q;
  logic                  overflow_q;
  logic                  underrun_q;
  logic                  tick_q;
  logic [7:0]            sample_q;
  logic [7:0]            sample_next;
  logic                  tick;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  underrun_ev;

  // A tick fires once the counter reaches rate_div; >= makes a lowered rate_div fire at once.
  assign tick = bus.enable && (div_cnt >= bus.rate_div);

  // Decide pop/push/drop, the next FIFO level and the next DAC sample.
  always_comb begin
    pop         = tick && (level != '0) && !bus.flush;
    push        = bus.wr_valid && !bus.flush && ((level != LEVEL_FULL) || pop);
    drop        = bus.wr_valid && !bus.flush && (level == LEVEL_FULL) && !pop;
    underrun_ev = tick && (level == '0);

    level_next = level;
    if (bus.flush) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = level + 1'b1;
    end else if (pop && !push) begin
      level_next = level - 1'b1;
    end

    sample_next = sample_q;
    if (!bus.enable) begin
      sample_next = MIDSCALE;
    end else if (pop) begin
      sample_next = fifo_mem[rd_ptr];
    end else if (underrun_ev && !UNDERRUN_HOLD) begin
      sample_next = MIDSCALE;
    end
  end

  // Rate divider: held at 0 while disabled, restarts from 0 after every tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!bus.enable || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // FIFO storage; contents need no reset because level/pointers qualify them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Read/write pointers wrap modulo depth; flush returns both to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Level and registered full/empty, all derived from the same next level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      level   <= level_next;
      full_q  <= (level_next == LEVEL_FULL);
      empty_q <= (level_next == '0);
    end
  end

  // Sample output and its update strobe change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= MIDSCALE;
      tick_q   <= 1'b0;
    end else begin
      sample_q <= sample_next;
      tick_q   <= tick;
    end
  end

  // Sticky flags; a set event in the same cycle as clear_flags keeps the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overflow_q <= drop        || (overflow_q && !bus.clear_flags);
      underrun_q <= underrun_ev || (underrun_q && !bus.clear_flags);
    end
  end

  assign bus.sample_out  = sample_q;
  assign bus.sample_tick = tick_q;
  assign bus.fifo_level  = level;
  assign bus.fifo_full   = full_q;
  assign bus.fifo_empty  = empty_q;
  assign bus.overflow    = overflow_q;
  assign bus.underrun    = underrun_q;

endmodule

// File: tb/tb_stream_sample_scheduler.sv
// Scoreboard testbench for stream_sample_scheduler: a queue-based reference
// model predicts each cycle's outputs; a monitor compares them after each edge.
module tb_stream_sample_scheduler;

  localparam int         DEPTH_LOG2    = 3;
  localparam int         DIV_W         = 16;
  localparam int         DEPTH         = 8;
  localparam logic [7:0] MIDSCALE      = 8'h80;
  localparam bit         UNDERRUN_HOLD = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  stream_sample_scheduler_if #(.DEPTH_LOG2(DEPTH_LOG2), .DIV_W(DIV_W)) bus ();

  stream_sample_scheduler #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DIV_W(DIV_W),
    .MIDSCALE(MIDSCALE),
    .UNDERRUN_HOLD(UNDERRUN_HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sample;
    logic       tick;
    logic [3:0] level;
    logic       full;
    logic       empty;
    logic       ov;
    logic       un;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] tickQ[$];
  int         passed = 0;
  int         total  = 0;

  logic [7:0]  mq[$];
  int unsigned mcnt = 0;
  logic [7:0]  msample = MIDSCALE;
  bit          mov = 1'b0;
  bit          mun = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one clock edge worth of behaviour using a byte queue.
  task automatic modelStep();
    exp_t e;
    bit tick, ov_ev, un_ev;
    tick = 1'b0;
    if (!rst_n) begin
      mq.delete();
      mcnt    = 0;
      msample = MIDSCALE;
      mov     = 1'b0;
      mun     = 1'b0;
    end else begin
      ov_ev = 1'b0;
      un_ev = 1'b0;
      tick  = bus.enable && (mcnt >= bus.rate_div);
      mcnt  = (bus.enable && !tick) ? mcnt + 1 : 0;
      if (tick) begin
        if (mq.size() == 0) begin
          un_ev = 1'b1;
          if (!UNDERRUN_HOLD) msample = MIDSCALE;
        end else if (!bus.flush) begin
          msample = mq.pop_front();
        end
      end
      if (bus.flush) mq.delete();
      else if (bus.wr_valid) begin
        if (mq.size() < DEPTH) mq.push_back(bus.wr_data);
        else ov_ev = 1'b1;
      end
      if (!bus.enable) msample = MIDSCALE;
      mov = ov_ev || (mov && !bus.clear_flags);
      mun = un_ev || (mun && !bus.clear_flags);
      if (tick) tickQ.push_back(msample);
    end
    e.sample = msample;
    e.tick   = tick;
    e.level  = 4'(mq.size());
    e.full   = (mq.size() == DEPTH);
    e.empty  = (mq.size() == 0);
    e.ov     = mov;
    e.un     = mun;
    expQ.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge and record the prediction.
  task automatic applyStimulus(input bit rn, input bit en, input bit fl, input bit wv,
                               input logic [7:0] wd, input int rd, input bit cf);
    @(negedge clk);
    rst_n           = rn;
    bus.enable      = en;
    bus.flush       = fl;
    bus.wr_valid    = wv;
    bus.wr_data     = wd;
    bus.rate_div    = DIV_W'(rd);
    bus.clear_flags = cf;
    modelStep();
  endtask

  // Compare every output against the prediction for this edge.
  task automatic checkOutput(input exp_t e);
    logic [7:0] s;
    check("sample_out",  bus.sample_out,  e.sample);
    check("sample_tick", bus.sample_tick, e.tick);
    check("fifo_level",  bus.fifo_level,  e.level);
    check("fifo_full",   bus.fifo_full,   e.full);
    check("fifo_empty",  bus.fifo_empty,  e.empty);
    check("overflow",    bus.overflow,    e.ov);
    check("underrun",    bus.underrun,    e.un);
    if (bus.sample_tick) begin
      if (tickQ.size() == 0) begin
        total++;
        $display("[TB] FAIL tick_unexpected: got tick with sample 0x%0h, expected no tick at %0t",
                 bus.sample_out, $time);
      end else begin
        s = tickQ.pop_front();
        check("tick_sample", bus.sample_out, s);
      end
    end
  endtask

  // Monitor: sample outputs 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  bit ren;
  int rrd;

  initial begin
    bus.enable = 1'b0; bus.flush = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = 8'h00;
    bus.rate_div = '0; bus.clear_flags = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_sample_out",  bus.sample_out,  8'h80);
    check("reset_sample_tick", bus.sample_tick, 1'b0);
    check("reset_fifo_level",  bus.fifo_level,  4'd0);
    check("reset_fifo_empty",  bus.fifo_empty,  1'b1);
    check("reset_fifo_full",   bus.fifo_full,   1'b0);
    check("reset_overflow",    bus.overflow,    1'b0);
    check("reset_underrun",    bus.underrun,    1'b0);

    repeat (2) applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);

    // free-running ticks with an empty FIFO
    repeat (14) applyStimulus(1, 1, 0, 0, 8'h00, 3, 0);

    // prefill three bytes while disabled, then play them out and underrun
    applyStimulus(1, 0, 0, 0, 8'h00, 9, 1);
    applyStimulus(1, 0, 0, 1, 8'h11, 9, 0);
    applyStimulus(1, 0, 0, 1, 8'h22, 9, 0);
    applyStimulus(1, 0, 0, 1, 8'h33, 9, 0);
    repeat (45) applyStimulus(1, 1, 0, 0, 8'h00, 9, 0);

    // overfill by one byte, then drain
    applyStimulus(1, 0, 1, 0, 8'h00, 2, 1);
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 1, 8'(i), 2, 0);
    repeat (30) applyStimulus(1, 1, 0, 0, 8'h00, 2, 0);

    // full FIFO at rate 0 with a write every cycle
    applyStimulus(1, 0, 1, 0, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 1, 8'(8'h60 + i), 0, 0);

    // mid-playback flush, refill, then enable drop
    applyStimulus(1, 1, 1, 0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 1, 8'(8'h70 + i), 1, 0);
    repeat (3) applyStimulus(1, 1, 0, 0, 8'h00, 1, 0);
    repeat (6) applyStimulus(1, 0, 0, 0, 8'h00, 1, 0);

    // clear_flags colliding with an underrun tick, then alone
    applyStimulus(1, 0, 1, 0, 8'h00, 2, 1);
    repeat (2) applyStimulus(1, 1, 0, 0, 8'h00, 2, 0);
    applyStimulus(1, 1, 0, 0, 8'h00, 2, 1);
    applyStimulus(1, 1, 0, 0, 8'h00, 2, 1);
    repeat (2) applyStimulus(1, 1, 0, 0, 8'h00, 2, 0);

    // reset in the middle of playback discards FIFO contents
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 1, 8'(8'hA0 + i), 4, 0);
    applyStimulus(0, 1, 0, 1, 8'hEE, 4, 0);
    repeat (12) applyStimulus(1, 1, 0, 0, 8'h00, 4, 0);

    // randomized traffic
    ren = 1'b1;
    rrd = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) ren = ~ren;
      if ($urandom_range(0, 19) == 0) rrd = int'($urandom_range(0, 6));
      applyStimulus($urandom_range(0, 599) != 0, ren, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 2) == 0, 8'($urandom), rrd, $urandom_range(0, 24) == 0);
    end

    applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
    @(posedge clk);
    #3;
    check("pending_expectations", expQ.size(), 0);
    check("pending_ticks", tickQ.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
